cpu_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the class CPU. It runs the per-instruction FETCH/DECODE/EXEC/MEM/WB cycle and performs the instruction- and data-memory request/acknowledge handshakes. It drives the program counter's `load_instr` enable exactly once per retired instruction and holds the instruction register that feeds the decoder, register file and PC jump/branch inputs.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/cpu_seq_ctrl_if.sv | 21 ++
 rtl/cpu_seq_ctrl.sv | 75 +++++++
 tb/tb_cpu_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control slice: sequencer state encodings.
package cpu_ctrl_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Instruction/data memory request-acknowledge bus between sequencer and memories.
interface cpu_seq_ctrl_if #(
    parameter int unsigned BITS = 32
);
    logic            imem_req;
    logic            imem_ack;
    logic [BITS-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with instruction register
// and retired-instruction counter.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   run,
    cpu_seq_ctrl_if.master         bus,
    output logic [BITS-1:0]        instr,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    input  logic                   reg_wr,
    input  logic                   halt_instr,
    output logic                   rf_we,
    output logic                   load_instr,
    output logic                   halted,
    output logic [SEQ_STATE_W-1:0] state,
    output logic [BITS-1:0]        retired
);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [BITS-1:0] instr_q;
    logic [BITS-1:0] retired_q;

    // Next-state selection; the unused encoding 7 falls back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   if (bus.imem_ack) state_d = DECODE;
            DECODE:  state_d = halt_instr ? HALT : EXEC;
            EXEC:    state_d = (mem_rd || mem_wr) ? MEM : WB;
            MEM:     if (bus.dmem_ack) state_d = WB;
            WB:      state_d = FETCH;
            HALT:    if (run) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state and the instruction decode bits.
    always_comb begin
        bus.imem_req = (state_q == FETCH);
        bus.dmem_req = (state_q == MEM);
        bus.dmem_we  = (state_q == MEM) && mem_wr;
        rf_we        = (state_q == WB) && reg_wr;
        halted       = (state_q == HALT);
        load_instr   = (state_q == WB) || ((state_q == HALT) && run);
    end

    // State register, instruction capture on fetch ack, retire counter.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == FETCH) && bus.imem_ack) begin
                instr_q <= bus.imem_rdata;
            end
            if (load_instr) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign instr   = instr_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed-vector bench for the instruction sequencer.
module tb_cpu_seq_ctrl;

    localparam int unsigned BITS = 32;

    localparam logic [BITS-1:0] ALU_W   = 32'h0123_4567;
    localparam logic [BITS-1:0] LOAD_W  = 32'h8C41_0004;
    localparam logic [BITS-1:0] STORE_W = 32'hAC41_0008;
    localparam logic [BITS-1:0] HALT_W  = 32'hFFFF_0000;
    localparam logic [BITS-1:0] LOAD2_W = 32'h8C42_0010;
    localparam logic [BITS-1:0] ALU2_W  = 32'h0246_8ACE;

    logic            clk;
    logic            rst_;
    logic            run;
    logic [BITS-1:0] instr;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
    logic            halt_instr;
    logic            rf_we;
    logic            load_instr;
    logic            halted;
    logic [2:0]      state;
    logic [BITS-1:0] retired;

    cpu_seq_ctrl_if #(.BITS(BITS)) bus ();

    cpu_seq_ctrl #(.BITS(BITS)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .run        (run),
        .bus        (bus.master),
        .instr      (instr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .reg_wr     (reg_wr),
        .halt_instr (halt_instr),
        .rf_we      (rf_we),
        .load_instr (load_instr),
        .halted     (halted),
        .state      (state),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int n_ireq, n_dreq, n_dwe, n_rfwe, n_load, n_halt, n_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_ireq = 0; n_dreq = 0; n_dwe = 0; n_rfwe = 0; n_load = 0; n_halt = 0; n_cyc = 0;
    endtask

    task automatic sample();
        n_cyc++;
        if (bus.imem_req) n_ireq++;
        if (bus.dmem_req) n_dreq++;
        if (bus.dmem_we)  n_dwe++;
        if (rf_we)        n_rfwe++;
        if (load_instr)   n_load++;
        if (halted)       n_halt++;
    endtask

    // Advance one clock and observe the new cycle away from the edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        sample();
    endtask

    initial begin
        rst_ = 1'b0; run = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0; halt_instr = 1'b0;
        clear_counts();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_state", state, 0);
        check_eq("rst_outs", {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, load_instr, halted}, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_retired", retired, 0);

        // ALU instruction, imem_ack tied high: FETCH, DECODE, EXEC, WB
        rst_ = 1'b1; run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = ALU_W; reg_wr = 1'b1;
        clear_counts();
        tick(); run = 1'b0;
        check_eq("alu_c1_fetch", state, 1);
        check_eq("alu_c1_ireq", bus.imem_req, 1);
        tick();
        check_eq("alu_c2_decode", state, 2);
        check_eq("alu_instr", instr, ALU_W);
        tick();
        check_eq("alu_c3_exec", state, 3);
        tick();
        check_eq("alu_c4_wb", state, 5);
        check_eq("alu_c4_load", load_instr, 1);
        check_eq("alu_c4_rfwe", rf_we, 1);
        bus.imem_ack = 1'b0;
        tick();
        check_eq("alu_refetch", state, 1);
        check_eq("alu_load_cnt", n_load, 1);
        check_eq("alu_rfwe_cnt", n_rfwe, 1);
        check_eq("alu_retired", retired, 1);

        // Load: imem_ack 3 cycles late, dmem_ack 2 cycles late
        mem_rd = 1'b1; mem_wr = 1'b0; reg_wr = 1'b1; bus.imem_rdata = LOAD_W;
        clear_counts();
        sample();
        tick(); tick(); tick();
        check_eq("ld_wait_fetch", state, 1);
        check_eq("ld_instr_hold", instr, ALU_W);
        bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0; bus.imem_rdata = ALU2_W;
        check_eq("ld_decode", state, 2);
        check_eq("ld_instr", instr, LOAD_W);
        tick();
        check_eq("ld_exec", state, 3);
        tick(); tick(); tick();
        check_eq("ld_mem_wait", state, 4);
        bus.dmem_ack = 1'b1;
        tick(); bus.dmem_ack = 1'b0;
        check_eq("ld_wb", state, 5);
        check_eq("ld_rfwe", rf_we, 1);
        check_eq("ld_ireq_cnt", n_ireq, 4);
        check_eq("ld_dreq_cnt", n_dreq, 3);
        check_eq("ld_dwe_cnt", n_dwe, 0);
        check_eq("ld_load_cnt", n_load, 1);
        check_eq("ld_cycles", n_cyc, 4 + 1 + 1 + 3 + 1);
        check_eq("ld_instr_stable", instr, LOAD_W);
        tick();
        check_eq("ld_retired", retired, 2);

        // Store with both mem_rd and mem_wr set, acks immediate
        mem_rd = 1'b1; mem_wr = 1'b1; reg_wr = 1'b0; bus.imem_rdata = STORE_W;
        bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
        clear_counts();
        sample();
        tick(); bus.imem_ack = 1'b0;
        tick();
        tick();
        check_eq("st_mem", state, 4);
        check_eq("st_dwe", bus.dmem_we, 1);
        tick();
        check_eq("st_wb", state, 5);
        check_eq("st_rfwe", rf_we, 0);
        check_eq("st_dwe_cnt", n_dwe, 1);
        check_eq("st_cycles", n_cyc, 5);
        tick(); bus.dmem_ack = 1'b0;
        check_eq("st_retired", retired, 3);

        // HALT: stays halted for 10 cycles, then exits on run
        mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0; halt_instr = 1'b1;
        bus.imem_rdata = HALT_W; bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        check_eq("hlt_decode_lo", halted, 0);
        tick();
        check_eq("hlt_state", state, 6);
        check_eq("hlt_halted", halted, 1);
        clear_counts();
        for (int i = 0; i < 10; i++) tick();
        check_eq("hlt_stay", state, 6);
        check_eq("hlt_no_load", n_load, 0);
        check_eq("hlt_no_req", n_ireq + n_dreq, 0);
        check_eq("hlt_cnt", n_halt, 10);
        run = 1'b1; halt_instr = 1'b0;
        #1;
        check_eq("hlt_exit_load", load_instr, 1);
        tick(); run = 1'b0;
        check_eq("hlt_resume", state, 1);
        check_eq("hlt_fall", halted, 0);
        check_eq("hlt_retired", retired, 4);

        // Reset during MEM with dmem_req high, late ack afterwards
        mem_rd = 1'b1; reg_wr = 1'b1; bus.imem_rdata = LOAD2_W; bus.imem_ack = 1'b1;
        tick(); bus.imem_ack = 1'b0;
        tick();
        tick();
        check_eq("rmem_dreq", bus.dmem_req, 1);
        rst_ = 1'b0;
        #1;
        check_eq("rmem_state", state, 0);
        check_eq("rmem_outs", {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, load_instr, halted}, 0);
        check_eq("rmem_instr", instr, 0);
        check_eq("rmem_retired", retired, 0);
        @(negedge clk);
        rst_ = 1'b1; bus.dmem_ack = 1'b1; bus.imem_ack = 1'b1;
        tick();
        check_eq("late_ack_state", state, 0);
        check_eq("late_ack_dreq", bus.dmem_req, 0);
        check_eq("late_ack_retired", retired, 0);
        bus.dmem_ack = 1'b0; bus.imem_ack = 1'b0;

        // Retire counter wrap from all ones
        force dut.retired_q = {BITS{1'b1}};
        #1;
        release dut.retired_q;
        #1;
        check_eq("wrap_preload", retired, {BITS{1'b1}});
        mem_rd = 1'b0; reg_wr = 1'b1; run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = ALU_W;
        tick(); run = 1'b0;
        tick(); bus.imem_ack = 1'b0;
        tick();
        tick();
        check_eq("wrap_wb_load", load_instr, 1);
        tick();
        check_eq("wrap_retired", retired, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
